// File: rtl/mips_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_regfile_if
// Description : Port bundle of the MIPS register file. It carries two operand
//               read ports, one writeback port with an overflow qualifier, the
//               overflow trap pulse and a debug read port.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_regfile_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [WIDTH-1:0]  wd;
    logic              wb_ovf;
    logic              ovf_trap;
    logic [ADDR_W-1:0] dbg_ra;
    logic [WIDTH-1:0]  dbg_rd;

    // Pipeline side: issues addresses and writeback, consumes read data
    modport master (
        output ra1, ra2, we, wa, wd, wb_ovf, dbg_ra,
        input  rd1, rd2, ovf_trap, dbg_rd
    );

    // Register file side
    modport slave (
        input  ra1, ra2, we, wa, wd, wb_ovf, dbg_ra,
        output rd1, rd2, ovf_trap, dbg_rd
    );
endinterface
`default_nettype wire

// File: rtl/mips_regfile.sv
`default_nettype none
// ============================================================================
// Module      : mips_regfile
// Description : 32 x 32-bit MIPS general-purpose register file. Register $0
//               is hardwired to zero. There are two combinational operand read
//               ports and one combinational debug read port. The single write
//               port is suppressed by the writeback overflow flag, and a
//               blocked write raises ovf_trap for one cycle.
//               Optional feature macro: REGFILE_BYPASS_EN. When it is defined,
//               a write-through bypass forwards wd to any read port whose
//               address matches an accepted write in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_regfile #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  wire              clk,
    input  wire              reset,
    mips_regfile_if.slave    bus
);

    localparam int                c_DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_ZERO  = '0;

    // An accepted write must be enabled, free of overflow, and not aimed at $0
    logic w_wr_en;
    logic w_ovf_block;

    assign w_wr_en     = bus.we & ~bus.wb_ovf & (bus.wa != c_ZERO);
    assign w_ovf_block = bus.we &  bus.wb_ovf & (bus.wa != c_ZERO);

    // Stored values. Entry 0 is a constant, so no flop exists for $0.
    logic [WIDTH-1:0] w_regs [c_DEPTH];

    assign w_regs[0] = '0;

    for (genvar gi = 1; gi < c_DEPTH; gi++) begin : g_reg
        logic [WIDTH-1:0] r_val;

        // One register: cleared by reset, loaded when an accepted write targets it
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_val <= '0;
            end else if (w_wr_en && (bus.wa == ADDR_W'(gi))) begin
                r_val <= bus.wd;
            end
        end

        assign w_regs[gi] = r_val;
    end

    // Trap flag: a one-cycle pulse after each write blocked by overflow
    logic r_ovf_trap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf_trap <= 1'b0;
        end else begin
            r_ovf_trap <= w_ovf_block;
        end
    end

    assign bus.ovf_trap = r_ovf_trap;

    // Read ports. w_wr_en already excludes address 0 and overflow-blocked
    // writes, so the bypass can never return data for $0.
`ifdef REGFILE_BYPASS_EN
    assign bus.rd1    = (w_wr_en && (bus.ra1    == bus.wa)) ? bus.wd : w_regs[bus.ra1];
    assign bus.rd2    = (w_wr_en && (bus.ra2    == bus.wa)) ? bus.wd : w_regs[bus.ra2];
    assign bus.dbg_rd = (w_wr_en && (bus.dbg_ra == bus.wa)) ? bus.wd : w_regs[bus.dbg_ra];
`else
    assign bus.rd1    = w_regs[bus.ra1];
    assign bus.rd2    = w_regs[bus.ra2];
    assign bus.dbg_rd = w_regs[bus.dbg_ra];
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_regfile
// Description : Directed self-checking bench for mips_regfile. It covers
//               reset, write/read, $0, overflow blocking and trap, same-cycle
//               read/write in both builds, and reset dominating a write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_regfile;

    logic clk;
    logic reset;

    int n_checks;
    int n_pass;

    mips_regfile_if #(.WIDTH(32), .ADDR_W(5)) bus ();

    mips_regfile #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present an accepted write on the next rising edge, then release we
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we     = 1'b1;
        bus.wb_ovf = 1'b0;
        bus.wa     = a;
        bus.wd     = d;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        reset      = 1'b1;
        bus.ra1    = '0;
        bus.ra2    = '0;
        bus.we     = 1'b0;
        bus.wa     = '0;
        bus.wd     = '0;
        bus.wb_ovf = 1'b0;
        bus.dbg_ra = '0;

        // Reset state
        #2;
        bus.ra1 = 5'd5;
        bus.dbg_ra = 5'd31;
        #1;
        check("reset_rd1", bus.rd1, 32'h0);
        check("reset_dbg", bus.dbg_rd, 32'h0);
        check("reset_trap", {31'b0, bus.ovf_trap}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // 1: write $5, then assert reset mid-cycle with no clock edge
        wr(5'd5, 32'hDEAD_BEEF);
        bus.ra1 = 5'd5;
        #1;
        check("t1_written", bus.rd1, 32'hDEAD_BEEF);
        reset = 1'b1;
        #1;
        check("t1_async_clr", bus.rd1, 32'h0);
        check("t1_trap", {31'b0, bus.ovf_trap}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // 2: write $7, read through both ports
        wr(5'd7, 32'h0000_1234);
        bus.ra1 = 5'd7;
        bus.ra2 = 5'd7;
        #1;
        check("t2_rd1", bus.rd1, 32'h0000_1234);
        check("t2_rd2", bus.rd2, 32'h0000_1234);

        // 3: write to $0 is ignored
        wr(5'd0, 32'hFFFF_FFFF);
        bus.ra1    = 5'd0;
        bus.dbg_ra = 5'd0;
        #1;
        check("t3_rd1_zero", bus.rd1, 32'h0);
        check("t3_dbg_zero", bus.dbg_rd, 32'h0);
        check("t3_no_trap", {31'b0, bus.ovf_trap}, 32'h0);

        // 4: overflow blocks a write and pulses the trap for one cycle
        wr(5'd9, 32'h1);
        @(negedge clk);
        bus.we     = 1'b1;
        bus.wa     = 5'd9;
        bus.wd     = 32'h8000_0000;
        bus.wb_ovf = 1'b1;
        bus.ra1    = 5'd9;
        #1;
        check("t4_no_bypass", bus.rd1, 32'h1);
        @(posedge clk);
        #1;
        bus.we     = 1'b0;
        bus.dbg_ra = 5'd9;
        #1;
        check("t4_trap_hi", {31'b0, bus.ovf_trap}, 32'h1);
        check("t4_kept", bus.dbg_rd, 32'h1);
        @(posedge clk);
        #1;
        check("t4_trap_lo", {31'b0, bus.ovf_trap}, 32'h0);
        check("t4_kept2", bus.rd1, 32'h1);
        // wb_ovf without we must not trap
        @(posedge clk);
        #1;
        check("t4_ovf_no_we", {31'b0, bus.ovf_trap}, 32'h0);
        bus.wb_ovf = 1'b0;

        // Distinct addresses on the two ports
        bus.ra1 = 5'd7;
        bus.ra2 = 5'd9;
        #1;
        check("pair_rd1", bus.rd1, 32'h0000_1234);
        check("pair_rd2", bus.rd2, 32'h1);

        // 5: same-cycle read/write of the same address
        wr(5'd3, 32'hA);
        @(negedge clk);
        bus.we     = 1'b1;
        bus.wa     = 5'd3;
        bus.wd     = 32'hB;
        bus.ra1    = 5'd3;
        bus.dbg_ra = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("t5_same_cycle", bus.rd1, 32'hB);
        check("t5_same_dbg", bus.dbg_rd, 32'hB);
`else
        check("t5_same_cycle", bus.rd1, 32'hA);
        check("t5_same_dbg", bus.dbg_rd, 32'hA);
`endif
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        #1;
        check("t5_after_edge", bus.rd1, 32'hB);

        // 6: reset and write on the same edge; reset wins
        @(negedge clk);
        reset   = 1'b1;
        bus.we  = 1'b1;
        bus.wa  = 5'd4;
        bus.wd  = 32'h55;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset  = 1'b0;
        bus.we = 1'b0;
        bus.ra1 = 5'd4;
        bus.ra2 = 5'd7;
        #1;
        check("t6_reg4", bus.rd1, 32'h0);
        check("t6_reg7_clr", bus.rd2, 32'h0);

        // Register file is usable again after reset
        wr(5'd31, 32'hCAFE_F00D);
        bus.dbg_ra = 5'd31;
        #1;
        check("post_reset_wr", bus.dbg_rd, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
